// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive side of the VGA sync loopback.
// Watches hSync/vSync, rebuilds the pixel coordinates, checks each line and frame
// against the configured timing, and reports lock and timing errors.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   pix_en       pixel strobe; all state advances only on clk edges with pix_en=1
//   hSync/vSync  sync inputs from the timing generator (polarity set by SYNC_LOW)
//   locked       timing verified
//   active       locked and current pixel visible
//   x, y         visible column/row, 0 when active=0
//   frame_start  1-clk pulse on vSync assertion while in or entering lock
//   err          1-clk pulse on a timing violation
//   err_code     last error: 0 line length, 1 hsync width, 2 vsync width, 3 frame length
module vga_sync_decoder #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hSync,
    input  logic       vSync,
    output logic       locked,
    output logic       active,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frame_start,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_SYNC_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0]  H_VIS_LO    = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_VIS_HI    = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_SYNC_N    = 10'(V_SYNC);
    localparam logic [9:0]  V_VIS_LO    = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_VIS_HI    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] V_TOTAL_N   = 11'(V_TOTAL);

    localparam logic [1:0] ERR_LINE_LEN  = 2'd0;
    localparam logic [1:0] ERR_HSYNC_W   = 2'd1;
    localparam logic [1:0] ERR_VSYNC_W   = 2'd2;
    localparam logic [1:0] ERR_FRAME_LEN = 2'd3;

    typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

    state_e     state_q, state_d;
    logic       hs_q, vs_q;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       locked_q, locked_d;
    logic       active_q, active_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       frame_start_q, frame_start_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    // Sync levels normalised to "asserted"; samples are stored raw.
    logic hs_now, hs_prev, vs_now, vs_prev;
    logic hs_start, hs_end, vs_start, vs_end;

    assign hs_now   = hSync ^ SYNC_LOW;
    assign vs_now   = vSync ^ SYNC_LOW;
    assign hs_prev  = hs_q ^ SYNC_LOW;
    assign vs_prev  = vs_q ^ SYNC_LOW;
    assign hs_start = hs_now & ~hs_prev;
    assign hs_end   = ~hs_now & hs_prev;
    assign vs_start = vs_now & ~vs_prev;
    assign vs_end   = ~vs_now & vs_prev;

    // Candidate counter values; committed only on pix_en.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hs_start) begin
            hcnt_d = '0;
        end else if (hcnt_q != '1) begin
            hcnt_d = hcnt_q + 10'd1;
        end
        if (vs_start) begin
            vcnt_d = '0;
        end else if (hs_start && vcnt_q != '1) begin
            vcnt_d = vcnt_q + 10'd1;
        end
    end

    // Timing checks, live only outside SEARCH.
    logic       checking;
    logic       e_line, e_hsw, e_vsw, e_frame, err_any;
    logic [1:0] err_sel;

    always_comb begin
        checking = (state_q != StSearch);
        // A missing hs_start is caught on the edge where hcnt would step to H_TOTAL.
        e_line   = checking & (hs_start ? (hcnt_q != H_LAST) : (hcnt_q == H_LAST));
        e_hsw    = checking & hs_end & (hcnt_q != H_SYNC_LAST);
        // vcnt_d already includes a coincident hs_start, i.e. hs_start in (vs_start, vs_end].
        e_vsw    = checking & vs_end & (vcnt_d != V_SYNC_N);
        e_frame  = checking & vs_start & (({1'b0, vcnt_q} + {10'd0, hs_start}) != V_TOTAL_N);
        err_any  = pix_en & (e_line | e_hsw | e_vsw | e_frame);
        if (e_line) begin
            err_sel = ERR_LINE_LEN;
        end else if (e_hsw) begin
            err_sel = ERR_HSYNC_W;
        end else if (e_vsw) begin
            err_sel = ERR_VSYNC_W;
        end else begin
            err_sel = ERR_FRAME_LEN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StSearch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (pix_en) begin
            unique case (state_q)
                StSearch: if (vs_start) state_d = StCheck;
                StCheck: begin
                    if (err_any) begin
                        state_d = StSearch;
                    end else if (vs_start) begin
                        state_d = StLocked;
                    end
                end
                StLocked: if (err_any) state_d = StSearch;
                default:  state_d = StSearch;
            endcase
        end
    end

    // Output logic: computed from post-update counters and state.
    logic vis;

    always_comb begin
        locked_d      = locked_q;
        active_d      = active_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        vis           = 1'b0;
        if (pix_en) begin
            locked_d      = (state_d == StLocked);
            vis           = locked_d &&
                            (hcnt_d >= H_VIS_LO) && (hcnt_d <= H_VIS_HI) &&
                            (vcnt_d >= V_VIS_LO) && (vcnt_d <= V_VIS_HI);
            active_d      = vis;
            x_d           = vis ? (hcnt_d - H_VIS_LO) : 10'd0;
            y_d           = vis ? 9'(vcnt_d - V_VIS_LO) : 9'd0;
            frame_start_d = vs_start & (state_d == StLocked);
            err_d         = err_any;
            if (err_any) begin
                err_code_d = err_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            locked_q      <= 1'b0;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            if (pix_en) begin
                hs_q   <= hSync;
                vs_q   <= vSync;
                hcnt_q <= hcnt_d;
                vcnt_q <= vcnt_d;
            end
            locked_q      <= locked_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign locked      = locked_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a shrunken timing (15 px/line, 10 lines/frame)
// so several frames fit in a short run. The bench's own generator coordinates
// (gh, gv) define expected x/y/active: sync starts at gh=0 / gv=0.
module tb_vga_sync_decoder;

    // Horizontal: sync 0..2, back porch 3..4, active 5..12, front porch 13..14.
    // Vertical:   sync 0..1, back porch 2..3, active 4..8,  front porch 9.
    localparam int HVIS_LO = 5;
    localparam int HVIS_HI = 12;
    localparam int VVIS_LO = 4;
    localparam int VVIS_HI = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic       hSync = 1'b1;
    logic       vSync = 1'b1;
    logic       locked, active, frame_start, err;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] err_code;

    int checks = 0;
    int failures = 0;

    // Generator state.
    int gh, gv, cur_h, cur_v;
    int line_len = 15;
    int hsw = 3;
    int vsw = 2;
    int flen = 10;

    vga_sync_decoder #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hSync      (hSync),
        .vSync      (vSync),
        .locked     (locked),
        .active     (active),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit vis(int h, int v);
        return (h >= HVIS_LO) && (h <= HVIS_HI) && (v >= VVIS_LO) && (v <= VVIS_HI);
    endfunction

    // One pixel: pix_en high for one clk in four, syncs for pixel (gh, gv).
    task automatic strobe();
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        pix_en = 1'b1;
        hSync  = (gh < hsw) ? 1'b0 : 1'b1;
        vSync  = (gv < vsw) ? 1'b0 : 1'b1;
        cur_h  = gh;
        cur_v  = gv;
        @(posedge clk);
        #1;
        gh++;
        if (gh >= line_len) begin
            gh = 0;
            gv++;
            if (gv >= flen) gv = 0;
        end
    endtask

    task automatic run_until(int h, int v);
        for (int i = 0; i < 1000; i++) begin
            strobe();
            if (cur_h == h && cur_v == v) return;
        end
        failures++;
        $display("FAIL run_until: pixel (%0d,%0d) never reached, got (%0d,%0d)", h, v, cur_h, cur_v);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        pix_en = 1'b1;
        hSync  = 1'b0;
        vSync  = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        pix_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL reset_locked: got %b want 0", locked);
        end
        checks++;
        if (active !== 1'b0) begin
            failures++; $display("FAIL reset_active: got %b want 0", active);
        end
        checks++;
        if (x !== 10'd0 || y !== 9'd0) begin
            failures++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", x, y);
        end
        checks++;
        if (frame_start !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL reset_pulses: got fs=%b err=%b want 0 0", frame_start, err);
        end
        checks++;
        if (err_code !== 2'd0) begin
            failures++; $display("FAIL reset_err_code: got %0d want 0", err_code);
        end
    endtask

    task automatic test_lock();
        int vs_seen;
        logic [2:0] exp_v;
        gh = 7;
        gv = 9;
        vs_seen = 0;
        for (int i = 0; i < 400 && vs_seen < 2; i++) begin
            strobe();
            if (cur_h == 0 && cur_v == 0) vs_seen++;
            exp_v = (vs_seen == 2) ? 3'b110 : 3'b000;
            checks++;
            if ({locked, frame_start, err} !== exp_v) begin
                failures++;
                $display("FAIL lock_seq (%0d,%0d): got lock/fs/err=%b want %b",
                         cur_h, cur_v, {locked, frame_start, err}, exp_v);
            end
        end
        checks++;
        if (vs_seen != 2) begin
            failures++; $display("FAIL lock_vs_count: got %0d want 2", vs_seen);
        end
    endtask

    task automatic test_frame();
        int nact, nfs;
        bit ea;
        logic [22:0] act_v, exp_v;
        nact = 0;
        nfs  = 0;
        for (int i = 0; i < 150; i++) begin
            strobe();
            ea    = vis(cur_h, cur_v);
            exp_v = {1'b1, ea, ea ? 10'(cur_h - HVIS_LO) : 10'd0,
                     ea ? 9'(cur_v - VVIS_LO) : 9'd0, (cur_h == 0 && cur_v == 0), 1'b0};
            act_v = {locked, active, x, y, frame_start, err};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL frame_pixel (%0d,%0d): got %h want %h", cur_h, cur_v, act_v, exp_v);
            end
            if (active === 1'b1) nact++;
            if (frame_start === 1'b1) nfs++;
        end
        checks++;
        if (nact != 40) begin
            failures++; $display("FAIL frame_active_count: got %0d want 40", nact);
        end
        checks++;
        if (nfs != 1 || frame_start !== 1'b1) begin
            failures++; $display("FAIL frame_start_period: got %0d pulses want 1 at end", nfs);
        end
    endtask

    task automatic test_hsync_width();
        run_until(14, 2);
        hsw = 2;
        strobe();
        strobe();
        checks++;
        if ({err, locked} !== 2'b01) begin
            failures++; $display("FAIL hsw_pre: got err/lock=%b want 01", {err, locked});
        end
        strobe();
        hsw = 3;
        checks++;
        if ({err, err_code, locked} !== 4'b1010) begin
            failures++;
            $display("FAIL hsw_err: got err=%b code=%0d lock=%b want 1 1 0", err, err_code, locked);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL hsw_relock1: got %b want 0", locked);
        end
        run_until(0, 0);
        checks++;
        if ({locked, frame_start} !== 2'b11) begin
            failures++; $display("FAIL hsw_relock2: got lock/fs=%b want 11", {locked, frame_start});
        end
    endtask

    task automatic test_line_len();
        int npulse;
        run_until(13, 5);
        line_len = 16;
        strobe();
        npulse = (err === 1'b1) ? 1 : 0;
        strobe();
        line_len = 15;
        if (err === 1'b1) npulse++;
        strobe();
        if (err === 1'b1) npulse++;
        checks++;
        if (cur_h != 0 || cur_v != 6 || npulse != 1) begin
            failures++;
            $display("FAIL line_len_pulses: got %0d at (%0d,%0d) want 1 at (0,6)",
                     npulse, cur_h, cur_v);
        end
        checks++;
        if ({err_code, locked, active} !== 4'b0000) begin
            failures++;
            $display("FAIL line_len_state: got code=%0d lock=%b act=%b want 0 0 0",
                     err_code, locked, active);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL line_len_relock1: got %b want 0", locked);
        end
        run_until(0, 0);
        checks++;
        if ({locked, frame_start} !== 2'b11) begin
            failures++;
            $display("FAIL line_len_relock2: got lock/fs=%b want 11", {locked, frame_start});
        end
    endtask

    task automatic test_vsync_width();
        run_until(14, 9);
        vsw = 3;
        strobe();
        checks++;
        if ({locked, frame_start, err} !== 3'b110) begin
            failures++;
            $display("FAIL vsw_frame: got lock/fs/err=%b want 110", {locked, frame_start, err});
        end
        run_until(0, 2);
        checks++;
        if ({err, locked} !== 2'b01) begin
            failures++; $display("FAIL vsw_pre: got err/lock=%b want 01", {err, locked});
        end
        run_until(0, 3);
        vsw = 2;
        checks++;
        if ({err, err_code, locked} !== 4'b1100) begin
            failures++;
            $display("FAIL vsw_err: got err=%b code=%0d lock=%b want 1 2 0", err, err_code, locked);
        end
    endtask

    task automatic test_frame_len();
        run_until(0, 0);
        checks++;
        if ({locked, err} !== 2'b00) begin
            failures++; $display("FAIL flen_enter_check: got lock/err=%b want 00", {locked, err});
        end
        flen = 9;
        run_until(0, 0);
        flen = 10;
        checks++;
        if ({err, err_code, locked, frame_start} !== 5'b11100) begin
            failures++;
            $display("FAIL flen_err: got err=%b code=%0d lock=%b fs=%b want 1 3 0 0",
                     err, err_code, locked, frame_start);
        end
        run_until(0, 0);
        checks++;
        if ({locked, err} !== 2'b00) begin
            failures++; $display("FAIL flen_searched: got lock/err=%b want 00", {locked, err});
        end
        run_until(0, 0);
        checks++;
        if ({locked, frame_start} !== 2'b11) begin
            failures++; $display("FAIL flen_relock: got lock/fs=%b want 11", {locked, frame_start});
        end
    endtask

    task automatic test_stall();
        logic [21:0] exp_v;
        run_until(7, 5);
        exp_v = {1'b1, 10'd2, 9'd1, 1'b0, 1'b1};
        checks++;
        if ({active, x, y, err, locked} !== exp_v) begin
            failures++;
            $display("FAIL stall_pre: got %h want %h", {active, x, y, err, locked}, exp_v);
        end
        @(negedge clk);
        pix_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({active, x, y, err, locked} !== exp_v) begin
                failures++;
                $display("FAIL stall_hold clk%0d: got %h want %h", i, {active, x, y, err, locked}, exp_v);
            end
        end
        strobe();
        exp_v = {1'b1, 10'd3, 9'd1, 1'b0, 1'b1};
        checks++;
        if ({active, x, y, err, locked} !== exp_v) begin
            failures++;
            $display("FAIL stall_resume: got %h want %h", {active, x, y, err, locked}, exp_v);
        end
    endtask

    task automatic test_reset_mid_line();
        int nbad;
        run_until(9, 6);
        checks++;
        if ({active, x, y} !== {1'b1, 10'd4, 9'd2}) begin
            failures++; $display("FAIL rst_pre: got act=%b x=%0d y=%0d want 1 4 2", active, x, y);
        end
        @(negedge clk);
        reset  = 1'b1;
        pix_en = 1'b1;
        hSync  = (gh < hsw) ? 1'b0 : 1'b1;
        vSync  = (gv < vsw) ? 1'b0 : 1'b1;
        @(posedge clk);
        #1;
        gh++;
        checks++;
        if ({locked, active, x, y, frame_start, err, err_code} !== 25'd0) begin
            failures++;
            $display("FAIL rst_outputs: got %h want 0",
                     {locked, active, x, y, frame_start, err, err_code});
        end
        @(negedge clk);
        reset  = 1'b0;
        pix_en = 1'b0;
        nbad = 0;
        for (int i = 0; i < 100; i++) begin
            strobe();
            if (err !== 1'b0 || locked !== 1'b0) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            failures++; $display("FAIL rst_quiet: got %0d pixels with err/lock want 0", nbad);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_frame();
        test_hsync_width();
        test_line_len();
        test_vsync_width();
        test_frame_len();
        test_stall();
        test_reset_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
